// File: rtl/bus_d_writeback.sv
// rtl/bus_d_writeback.sv - D-bus write-back distributor to register file, data memory and FPGA output FIFO
module bus_d_writeback #(
    parameter int DATA_W     = 8,
    parameter int RF_AW      = 3,
    parameter int DM_AW      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_D,
    input  logic              wr_en,
    input  logic [1:0]        WD,
    input  logic [RF_AW-1:0]  DA,
    input  logic [DM_AW-1:0]  mem_addr,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_data,
    output logic [DATA_W-1:0] Fpga_out,
    output logic              Fpga_out_valid,
    input  logic              Fpga_out_ready,
    output logic              stall,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam logic [1:0] WD_RF   = 2'd1;
    localparam logic [1:0] WD_DM   = 2'd2;
    localparam logic [1:0] WD_FPGA = 2'd3;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    // Full FIFO refuses the push even if the head is leaving this cycle.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign stall = wr_en && (WD == WD_FPGA) && full;
    assign push  = wr_en && (WD == WD_FPGA) && !full;
    assign pop   = Fpga_out_valid && Fpga_out_ready;

    assign Fpga_out_valid = (count != '0);
    assign Fpga_out       = mem[rd_ptr];
    assign fifo_count     = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
            dm_we   <= 1'b0;
            dm_addr <= '0;
            dm_data <= '0;
        end else begin
            rf_we <= wr_en && (WD == WD_RF);
            dm_we <= wr_en && (WD == WD_DM);
            if (wr_en && (WD == WD_RF)) begin
                rf_addr <= DA;
                rf_data <= bus_D;
            end
            if (wr_en && (WD == WD_DM)) begin
                dm_addr <= mem_addr;
                dm_data <= bus_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus_D;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_d_writeback.sv
// tb/tb_bus_d_writeback.sv - directed and randomized bench for bus_d_writeback against a queue-based model
module tb_bus_d_writeback;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_D;
    logic       wr_en;
    logic [1:0] WD;
    logic [2:0] DA;
    logic [7:0] mem_addr;
    logic       rf_we;
    logic [2:0] rf_addr;
    logic [7:0] rf_data;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_data;
    logic [7:0] Fpga_out;
    logic       Fpga_out_valid;
    logic       Fpga_out_ready;
    logic       stall;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_rf_we, m_dm_we;
    logic [2:0] m_rf_addr;
    logic [7:0] m_rf_data, m_dm_addr, m_dm_data;

    bus_d_writeback dut (
        .clk(clk), .rst_n(rst_n), .bus_D(bus_D), .wr_en(wr_en), .WD(WD), .DA(DA),
        .mem_addr(mem_addr), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data), .Fpga_out(Fpga_out),
        .Fpga_out_valid(Fpga_out_valid), .Fpga_out_ready(Fpga_out_ready),
        .stall(stall), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check stall, advance the model at the edge, then check registered outputs.
    task automatic step(input logic rn, input logic we, input logic [1:0] wd, input logic [2:0] da,
                        input logic [7:0] d, input logic [7:0] ma, input logic rdy);
        logic full_now;
        rst_n = rn; wr_en = we; WD = wd; DA = da; bus_D = d; mem_addr = ma; Fpga_out_ready = rdy;
        #1;
        full_now = (q.size() == DEPTH);
        check("stall", stall, we && wd == 2'd3 && full_now);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_rf_we = 0; m_dm_we = 0; m_rf_addr = 0; m_rf_data = 0; m_dm_addr = 0; m_dm_data = 0;
        end else begin
            m_rf_we = we && wd == 2'd1;
            m_dm_we = we && wd == 2'd2;
            if (m_rf_we) begin m_rf_addr = da; m_rf_data = d; end
            if (m_dm_we) begin m_dm_addr = ma; m_dm_data = d; end
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (we && wd == 2'd3 && !full_now) q.push_back(d);
        end
        #1;
        check("rf_we", rf_we, m_rf_we);
        check("rf_addr", rf_addr, m_rf_addr);
        check("rf_data", rf_data, m_rf_data);
        check("dm_we", dm_we, m_dm_we);
        check("dm_addr", dm_addr, m_dm_addr);
        check("dm_data", dm_data, m_dm_data);
        check("fifo_count", fifo_count, q.size());
        check("valid", Fpga_out_valid, q.size() != 0);
        if (q.size() != 0) check("fpga_out", Fpga_out, q[0]);
        if (!rn) check("fpga_out_reset", Fpga_out, 8'h00);
    endtask

    initial begin
        logic [7:0] pushes [4];
        pushes[0] = 8'h11; pushes[1] = 8'h22; pushes[2] = 8'h33; pushes[3] = 8'h44;

        // Reset held with a pending FPGA write
        step(0, 1, 3, 0, 8'hEE, 0, 0);
        step(0, 1, 3, 0, 8'hEE, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Register-file write
        step(1, 1, 1, 3'd5, 8'hA5, 0, 0);
        check("rf_pulse_addr", rf_addr, 3'd5);
        check("rf_pulse_data", rf_data, 8'hA5);
        step(1, 0, 0, 0, 0, 0, 0);

        // WD=0 no-op, then data-memory write
        step(1, 1, 0, 3'd2, 8'h5A, 8'h10, 0);
        step(1, 1, 2, 0, 8'h7E, 8'h3C, 0);
        check("dm_pulse_addr", dm_addr, 8'h3C);
        step(1, 0, 0, 0, 0, 0, 0);

        // Fill FIFO, stall on 5th push, then release
        foreach (pushes[i]) step(1, 1, 3, 0, pushes[i], 0, 0);
        check("full_count", fifo_count, 3'd4);
        step(1, 1, 3, 0, 8'h55, 0, 0);
        step(1, 1, 3, 0, 8'h55, 0, 1);
        step(1, 1, 3, 0, 8'h55, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1);

        // Simultaneous push/pop at count 2
        step(1, 1, 3, 0, 8'h01, 0, 0);
        step(1, 1, 3, 0, 8'h02, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 3, 0, 8'h99, 0, 1);
        check("pushpop_count", fifo_count, 3'd2);

        // Reset mid-stream
        step(1, 1, 3, 0, 8'h03, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 8'hC3, 0, 0);
        check("post_reset_head", Fpga_out, 8'hC3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 3'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
